ysyx_23060187_inst_fetch: RTL and testbench



---
 rtl/ysyx_23060187_pkg.sv | 17 +
 rtl/ysyx_23060187_ifu_perf.sv | 32 +++
 rtl/ysyx_23060187_inst_fetch.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060187_inst_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 instruction fetch slice.
//   ifu_state_e      : fetch FSM encoding (IDLE, REQ, WAIT, HOLD)
//   NOP_INST         : word presented with out_fault (addi x0,x0,0)
//   DEFAULT_RESET_PC : default first fetch address
package ysyx_23060187_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060187_ifu_perf.sv
// Fetch performance counters.
//   clk, rst      : clock, synchronous active-high reset
//   i_fetch       : one instruction handed to the decoder this cycle
//   i_stall       : fetch waiting on memory this cycle
//   o_fetch_cnt   : 64-bit count of i_fetch cycles (wraps)
//   o_stall_cnt   : 64-bit count of i_stall cycles (wraps)
module ysyx_23060187_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch,
  input  logic        i_stall,
  output logic [63:0] o_fetch_cnt,
  output logic [63:0] o_stall_cnt
);

  logic [63:0] r_fetch_cnt;
  logic [63:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch) r_fetch_cnt <= r_fetch_cnt + 64'd1;
      if (i_stall) r_stall_cnt <= r_stall_cnt + 64'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/ysyx_23060187_inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction,
// holds the fetched word for the decoder, and absorbs redirects by dropping
// stale responses.
// Optional feature: define YSYX_23060187_IFU_PERF_EN to add the 64-bit
// perf_fetch_cnt / perf_stall_cnt outputs.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request (addr == pc)
//   imem_rsp_valid/data/err         : fetch response, one pulse per request
//   redirect_valid/pc               : load new PC (top priority)
//   out_valid/ready/inst/pc/fault   : registered instruction to decoder
module ysyx_23060187_inst_fetch
  import ysyx_23060187_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
`ifdef YSYX_23060187_IFU_PERF_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
`endif
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  ifu_state_e  r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic        r_out_valid;
  logic [31:0] r_out_inst;
  logic [31:0] r_out_pc;
  logic        r_out_fault;

  logic w_misaligned;
  logic w_req_fire;
  logic w_out_fire;

  // A misaligned PC never reaches memory; it becomes a fault in REQ.
  assign w_misaligned   = |r_pc[1:0];
  assign imem_req_valid = (r_state == S_REQ) && !w_misaligned;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_out_fire     = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_out_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      case (r_state)
        S_REQ: begin
          // Memory took the old-PC request; its response must be thrown away.
          if (w_req_fire) begin
            r_state <= S_WAIT;
            r_drop  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        S_HOLD: begin
          // A same-cycle decoder handshake is still consumed; pc comes from redirect.
          r_out_valid <= 1'b0;
          r_state     <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_misaligned) begin
            r_out_inst  <= NOP_INST;
            r_out_pc    <= r_pc;
            r_out_fault <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_out_inst  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
              r_out_pc    <= r_pc;
              r_out_fault <= imem_rsp_err;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_pc        <= r_pc + 32'd4;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_pc    = r_out_pc;
  assign out_fault = r_out_fault;

`ifdef YSYX_23060187_IFU_PERF_EN
  logic w_stall;
  assign w_stall = ((r_state == S_REQ) && !imem_req_ready) ||
                   ((r_state == S_WAIT) && !imem_rsp_valid);

  ysyx_23060187_ifu_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch     (w_out_fire),
    .i_stall     (w_stall),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060187_inst_fetch.sv
// Self-checking bench for ysyx_23060187_inst_fetch: memory model with
// configurable latency, decoder-side scoreboard, vector table for the
// straight-line fetch stream, hand-written redirect/stall/reset sequences.
module tb_ysyx_23060187_inst_fetch;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        mem_ready;
  logic [31:0] imem_req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
`ifdef YSYX_23060187_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ysyx_23060187_inst_fetch #(.RESET_PC(RPC)) dut (
`ifdef YSYX_23060187_IFU_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (mem_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .imem_rsp_err   (rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;     // address fetched
    logic        err;    // memory returns access fault
    logic [31:0] inst;   // expected out_inst
    logic        fault;  // expected out_fault
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int req_cnt = 0;
  int hs_cnt  = 0;
  int ov_cnt  = 0;
  int hs_cyc[64];
  logic [31:0] last_req_addr = '0;

  // memory model state
  int          mem_lat;
  logic [31:0] err_pc;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: responds mem_lat cycles after the cycle following acceptance.
  always @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      m_pend    <= 1'b0;
      m_cnt     <= 0;
      m_addr    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (imem_req_valid && mem_ready) begin
        if (mem_lat == 0) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mword(imem_req_addr);
          rsp_err   <= (imem_req_addr == err_pc);
        end else begin
          m_pend <= 1'b1;
          m_cnt  <= mem_lat - 1;
          m_addr <= imem_req_addr;
        end
      end else if (m_pend) begin
        if (m_cnt == 0) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mword(m_addr);
          rsp_err   <= (m_addr == err_pc);
          m_pend    <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Decoder-side monitor and scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req_valid && mem_ready) begin
          req_cnt++;
          last_req_addr = imem_req_addr;
        end
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL sb_unexpected: got pc %0h expected no handshake", out_pc);
          end else begin
            e = sb.pop_front();
            chk("sb_pc", {32'd0, out_pc}, {32'd0, e.pc});
            chk("sb_inst", {32'd0, out_inst}, {32'd0, e.inst});
            chk("sb_fault", {63'd0, out_fault}, {63'd0, e.fault});
          end
          if (hs_cnt < 64) hs_cyc[hs_cnt] = cyc;
          hs_cnt++;
        end
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    exp_t e;
    e.pc = pc; e.inst = inst; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  task automatic consume(input string nm);
    wait_valid(nm);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int   prev = req_cnt;
    logic ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_cnt != prev) begin ok = 1'b1; break; end
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({nm, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    chk({nm, "_pc"}, {32'd0, imem_req_addr}, {32'd0, RPC});
    chk({nm, "_out_pc"}, {32'd0, out_pc}, 64'd0);
`ifdef YSYX_23060187_IFU_PERF_EN
    chk({nm, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
    chk({nm, "_perf_stall"}, perf_stall_cnt, 64'd0);
`endif
  endtask

  task automatic release_reset(input string nm);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk({nm, "_req_lo"}, {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    chk({nm, "_req_hi"}, {63'd0, imem_req_valid}, 64'd1);
    chk({nm, "_req_addr"}, {32'd0, imem_req_addr}, {32'd0, RPC});
  endtask

  initial begin
    logic [31:0] held_inst;
    int ov0, rc0;

    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_ready = 1'b1; mem_lat = 0; err_pc = '0;

    vecs[0] = '{pc: RPC,        err: 1'b0, inst: mword(RPC),        fault: 1'b0};
    vecs[1] = '{pc: RPC + 32'h4, err: 1'b0, inst: mword(RPC + 32'h4), fault: 1'b0};
    vecs[2] = '{pc: RPC + 32'h8, err: 1'b1, inst: NOP,               fault: 1'b1};
    vecs[3] = '{pc: RPC + 32'hC, err: 1'b0, inst: mword(RPC + 32'hC), fault: 1'b0};

    repeat (3) tick();
    @(negedge clk);
    check_reset_state("rst");
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_out_fault", {63'd0, out_fault}, 64'd0);

    // Straight-line stream, decoder always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].pc, vecs[i].inst, vecs[i].fault);
      if (vecs[i].err) err_pc = vecs[i].pc;
    end
    release_reset("boot");
    for (int i = 0; i < 100 && hs_cnt < 4; i++) tick();
    out_ready = 1'b0;
    chk("table_hs_count", hs_cnt, 4);
    for (int i = 1; i < 4; i++) chk("hs_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

    // Decoder stalls 5 cycles in HOLD.
    push(RPC + 32'h10, mword(RPC + 32'h10), 1'b0);
    wait_valid("stall_valid_to");
    held_inst = out_inst;
    rc0 = req_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_pc", {32'd0, out_pc}, {32'd0, RPC + 32'h10});
      chk("stall_inst", {32'd0, out_inst}, {32'd0, held_inst});
      chk("stall_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("stall_pc_reg", {32'd0, imem_req_addr}, {32'd0, RPC + 32'h10});
    end
    chk("stall_req_cnt", req_cnt, rc0);
    consume("stall_consume_to");

    // Redirect while WAIT holds a slow response for 0x14.
    mem_lat = 3;
    wait_req("wait_req_to");
    ov0 = ov_cnt;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    push(32'h8000_0100, mword(32'h8000_0100), 1'b0);
    wait_req("redir_req_to");
    chk("redir_addr", {32'd0, last_req_addr}, 64'h8000_0100);
    chk("redir_no_valid", ov_cnt, ov0);
    mem_lat = 0;
    consume("redir_consume_to");

    // 0x104 sits in HOLD; redirect to a misaligned target.
    wait_valid("hold_valid_to");
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    rc0 = req_cnt;
    push(32'h8000_0102, NOP, 1'b1);
    wait_valid("mis_valid_to");
    chk("mis_fault", {63'd0, out_fault}, 64'd1);
    chk("mis_no_req", req_cnt, rc0);
    consume("mis_consume_to");

    // 0x106 also faults; redirect lands together with its handshake.
    push(32'h8000_0106, NOP, 1'b1);
    wait_valid("mis2_valid_to");
    tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    out_ready = 1'b0; redirect_valid = 1'b0;
    chk("hold_redir_hs", sb.size(), 0);
    wait_req("hold_redir_req_to");
    chk("hold_redir_addr", {32'd0, last_req_addr}, 64'h8000_0200);

    // Reset while WAIT.
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_state("midrst");
    push(RPC, mword(RPC), 1'b0);
    release_reset("midrst");
    consume("midrst_consume_to");
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
